// File: rtl/port_bank.sv
// port_bank: a bank of quasi-bidirectional I/O ports. Each port has an output latch,
// an IRQ mask and a write-1-to-clear falling-edge flag register. The bank drives
// one registered interrupt request.
//
// Ports:
//   clk, reset_n     : clock (rising edge); asynchronous active-low reset
//   sel, reg_sel     : port select; register select (0 latch, 1 mask, 2 flags, 3 reserved)
//   en, oe           : write strobe; read strobe (combinational read while high)
//   Bb               : 1 = byte/word access, 0 = single-bit access
//   position         : one-hot bit select used by bit accesses
//   din, bin         : word write data; bit write data
//   rmw              : latch-0 reads return the latch (1) or the synchronised pins (0)
//   dout, bout       : tri-state word read data; tri-state bit read data
//   pin_in, pin_out  : raw pad levels; output latches (port p at [p*WIDTH +: WIDTH])
//   irq              : registered OR of (flag & mask) over all ports
module port_bank #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WIDTH     = 8
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic [(NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1)-1:0] sel,
  input  logic [1:0]                                       reg_sel,
  input  logic                                             en,
  input  logic                                             oe,
  input  logic                                             Bb,
  input  logic [WIDTH-1:0]                                 position,
  input  logic [WIDTH-1:0]                                 din,
  input  logic                                             bin,
  input  logic                                             rmw,
  output logic [WIDTH-1:0]                                 dout,
  output logic                                             bout,
  input  logic [NUM_PORTS*WIDTH-1:0]                       pin_in,
  output logic [NUM_PORTS*WIDTH-1:0]                       pin_out,
  output logic                                             irq
);

  localparam int unsigned SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BUS_W = NUM_PORTS * WIDTH;

  // Architectural state
  logic [WIDTH-1:0] latch_q [NUM_PORTS];
  logic [WIDTH-1:0] mask_q  [NUM_PORTS];
  logic [WIDTH-1:0] flag_q  [NUM_PORTS];
  logic [BUS_W-1:0] sync1_q;
  logic [BUS_W-1:0] sync2_q;
  logic [BUS_W-1:0] hist_q;
  logic             irq_q;

  // Next-state values
  logic [WIDTH-1:0] latch_d [NUM_PORTS];
  logic [WIDTH-1:0] mask_d  [NUM_PORTS];
  logic [WIDTH-1:0] flag_d  [NUM_PORTS];
  logic             irq_d;

  logic             pos_ok_c;
  logic [WIDTH-1:0] wr_bits_c;
  logic [WIDTH-1:0] wr_val_c;
  logic [WIDTH-1:0] clr_c   [NUM_PORTS];
  logic [WIDTH-1:0] fall_c  [NUM_PORTS];
  logic [WIDTH-1:0] rd_word_c;
  logic             rd_bit_c;

  assign pos_ok_c = $onehot(position);

  // Byte access touches every bit; bit access touches only a valid one-hot position.
  assign wr_bits_c = Bb ? {WIDTH{1'b1}} : (pos_ok_c ? position : {WIDTH{1'b0}});
  assign wr_val_c  = Bb ? din : {WIDTH{bin}};

  // Next-state: register writes, W1C clears, falling-edge flag sets, irq
  always_comb begin
    irq_d = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      latch_d[p] = latch_q[p];
      mask_d[p]  = mask_q[p];
      clr_c[p]   = {WIDTH{1'b0}};
      fall_c[p]  = hist_q[p*WIDTH +: WIDTH] & ~sync2_q[p*WIDTH +: WIDTH];
      if (en && (sel == SEL_W'(p))) begin
        unique case (reg_sel)
          2'd0:    latch_d[p] = (latch_q[p] & ~wr_bits_c) | (wr_val_c & wr_bits_c);
          2'd1:    mask_d[p]  = (mask_q[p]  & ~wr_bits_c) | (wr_val_c & wr_bits_c);
          2'd2:    clr_c[p]   = wr_val_c & wr_bits_c;
          default: ;
        endcase
      end
      // Set is applied after the clear so a coincident edge wins.
      flag_d[p] = (flag_q[p] & ~clr_c[p]) | (fall_c[p] & mask_q[p]);
      if ((flag_q[p] & mask_q[p]) != {WIDTH{1'b0}}) begin
        irq_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        latch_q[p] <= {WIDTH{1'b1}};
        mask_q[p]  <= {WIDTH{1'b0}};
        flag_q[p]  <= {WIDTH{1'b0}};
      end
      sync1_q <= {BUS_W{1'b1}};
      sync2_q <= {BUS_W{1'b1}};
      hist_q  <= {BUS_W{1'b1}};
      irq_q   <= 1'b0;
    end else begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        latch_q[p] <= latch_d[p];
        mask_q[p]  <= mask_d[p];
        flag_q[p]  <= flag_d[p];
      end
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      irq_q   <= irq_d;
    end
  end

  // Read mux; out-of-range sel matches no port and reads zero
  always_comb begin
    rd_word_c = {WIDTH{1'b0}};
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (sel == SEL_W'(p)) begin
        unique case (reg_sel)
          2'd0:    rd_word_c = rmw ? latch_q[p] : sync2_q[p*WIDTH +: WIDTH];
          2'd1:    rd_word_c = mask_q[p];
          2'd2:    rd_word_c = flag_q[p];
          default: rd_word_c = {WIDTH{1'b0}};
        endcase
      end
    end
    rd_bit_c = pos_ok_c && ((rd_word_c & position) != {WIDTH{1'b0}});
  end

  // Pins mirror the latches directly
  always_comb begin
    pin_out = {BUS_W{1'b0}};
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      pin_out[p*WIDTH +: WIDTH] = latch_q[p];
    end
  end

  assign dout = (oe && Bb)  ? rd_word_c : {WIDTH{1'bz}};
  assign bout = (oe && !Bb) ? rd_bit_c  : 1'bz;
  assign irq  = irq_q;

endmodule

// File: doc/port_bank.md
PORT_BANK -- requirements
Module: port_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of I/O ports (1..8).
REQ-002 SHALL have parameter WIDTH, default 8, pins per port (2..16).
REQ-003 SHALL have port clk input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port sel input clog2(NUM_PORTS) (min 1), port select.
REQ-006 SHALL have port reg_sel input 2: 0 = output latch, 1 = IRQ mask, 2 = edge flags, 3 = reserved.
REQ-007 SHALL have port en input 1, write strobe.
REQ-008 SHALL have port oe input 1, read strobe to the internal bus.
REQ-009 SHALL have port Bb input 1: H = byte/word access, L = bit access.
REQ-010 SHALL have port position input WIDTH, one-hot bit select for bit access.
REQ-011 SHALL have port din input WIDTH, write data.
REQ-012 SHALL have port bin input 1, bit write data.
REQ-013 SHALL have port rmw input 1: H = latch-0 reads return the output latch; L = they return the synchronised pins.
REQ-014 SHALL have port dout output WIDTH, tri-state read data.
REQ-015 SHALL have port bout output 1, tri-state bit read data.
REQ-016 SHALL have port pin_in input NUM_PORTS*WIDTH, raw pad levels; port p occupies bits [p*WIDTH +: WIDTH].
REQ-017 SHALL have port pin_out output NUM_PORTS*WIDTH, output latch contents; quasi-bidirectional, latch 1 = weak high / input.
REQ-018 SHALL have port irq output 1, interrupt request.

Function
REQ-019 Each port SHALL hold a WIDTH-bit output latch, IRQ mask and edge-flag register; pin_out SHALL be the latches.
REQ-020 pin_in SHALL pass a 2-flop synchroniser per bit; pin reads and edge detection SHALL use only the second stage.
REQ-021 Byte write (en=1, Bb=1) SHALL load din into the register selected by sel/reg_sel at the next edge; for reg_sel=2 each din bit =1 SHALL clear that flag (write-1-to-clear).
REQ-022 Bit write (en=1, Bb=0) SHALL update only the bit selected by position with bin; reg_sel=2 with bin=1 SHALL clear that flag, bin=0 no effect.
REQ-023 A position that is not one-hot SHALL make bit writes no-ops and bit reads return 0.
REQ-024 Reads SHALL be combinational while oe=1: Bb=1 drives dout and leaves bout Z; Bb=0 drives bout and leaves dout Z; oe=0 SHALL hold both at Z.
REQ-025 Read data SHALL be: reg_sel 0 with rmw=1 the latch, with rmw=0 the synced pins; 1 the mask; 2 the flags; 3 zero.
REQ-026 sel >= NUM_PORTS SHALL make writes no-ops and reads return 0.
REQ-027 A falling edge on a synced pin (previous 1, current 0) with its mask bit set SHALL set its flag at that clock edge.
REQ-028 When a flag set and a W1C clear coincide on the same bit, the set SHALL win.
REQ-029 irq SHALL be registered: 1 the cycle after any (flag AND mask) is nonzero, 0 the cycle after none are.
REQ-030 Clearing a mask bit SHALL not clear its flag; it only removes the flag from irq.
REQ-031 Total latency: pad falling edge to irq high SHALL be 4 clk edges (2 sync, 1 flag, 1 irq).
REQ-032 Simultaneous en and oe to the same register SHALL return the pre-write value.

Reset
REQ-033 reset_n=0 SHALL asynchronously set all latches to all-ones, masks and flags to 0, synchroniser and edge-history flops to all-ones, and irq to 0.
REQ-034 Reset asserted mid-write SHALL discard the write; the first write after release SHALL be honoured on the first rising edge with reset_n=1.

Verification
REQ-035 Reset then read port 0 reg 0, rmw=1, Bb=1 -> dout=0xFF; pin_out all ones.
REQ-036 Byte write 0xA5 to port 2 reg 0, then bit write position=0x01, bin=0 -> latch 0xA4; pin_out[23:16]=0xA4; rmw=1 read -> 0xA4.
REQ-037 Port 1 mask=0x08; pin_in bit 11 high then low -> flag1=0x08 at the 3rd edge after the low, irq=1 at the 4th.
REQ-038 Write 0x08 to port 1 reg 2 while a new falling edge lands on bit 11 that same cycle -> flag stays 0x08, irq stays 1; a later clear alone -> flag 0x00, irq 0 one edge later.
REQ-039 NUM_PORTS=3, sel=3: byte write 0x00 -> no state change; read -> dout=0x00; position=0x03 bit read -> bout=0.
REQ-040 Assert reset_n during en=1 to port 0 with din=0x00 -> latch remains 0xFF, irq=0.
